// File: rtl/sieve_controller_mb.sv
// Run sequencer for NUM_BANKS parallel sieve banks followed by the prime-RAM populator.
// Define SIEVE_CTRL_TIMEOUT_EN to build the run watchdog and the sticky timed_out flag.
module sieve_controller_mb #(
    parameter int NUM_BANKS      = 4,
    parameter int MAX_W          = 16,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 calculate,
    input  logic [MAX_W-1:0]     max_prime_in,
    input  logic                 new_max_prime,
    input  logic                 abort,
    input  logic [NUM_BANKS-1:0] bank_done,
    input  logic                 populate_done,
    output logic                 start_calc,
    output logic [MAX_W-1:0]     max_prime,
    output logic                 calculating,
    output logic                 populating,
    output logic                 finished,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 timed_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_POP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

`ifdef SIEVE_CTRL_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_r;
    logic [NUM_BANKS-1:0] done_mask_r;
    logic                 start_calc_r;
    logic [MAX_W-1:0]     max_prime_r;
    logic [CNT_W-1:0]     cycle_count_r;

    logic                 active_s;
    logic                 abort_s;
    logic                 accept_s;
    logic                 trivial_s;
    logic                 watchdog_s;
    logic [NUM_BANKS-1:0] merged_mask_s;
    logic                 all_done_s;
    logic [CNT_W-1:0]     count_inc_s;

    // Request qualification, bank-done merging and saturating count increment.
    always_comb begin
        active_s      = (state_r == ST_CALC) || (state_r == ST_POP);
        abort_s       = abort && (state_r != ST_IDLE);
        if (state_r == ST_IDLE) begin
            accept_s = calculate;
        end else begin
            accept_s = new_max_prime && !abort;
        end
        trivial_s     = (max_prime_in < MAX_W'(2));
        watchdog_s    = WDOG_EN && active_s && (cycle_count_r == WDOG_LIMIT);
        merged_mask_s = done_mask_r | bank_done;
        all_done_s    = &merged_mask_s;
        if (cycle_count_r == CNT_MAX) begin
            count_inc_s = cycle_count_r;
        end else begin
            count_inc_s = cycle_count_r + CNT_W'(1);
        end
    end

    // Main sequencer: abort beats watchdog, which beats restart, which beats normal progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            done_mask_r   <= {NUM_BANKS{1'b0}};
            start_calc_r  <= 1'b0;
            max_prime_r   <= {MAX_W{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
        end else if (abort_s) begin
            state_r      <= ST_IDLE;
            start_calc_r <= 1'b0;
        end else if (watchdog_s) begin
            state_r       <= ST_IDLE;
            start_calc_r  <= 1'b0;
            cycle_count_r <= count_inc_s;
        end else if (accept_s) begin
            max_prime_r   <= max_prime_in;
            done_mask_r   <= {NUM_BANKS{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
            if (trivial_s) begin
                state_r      <= ST_FIN;
                start_calc_r <= 1'b0;
            end else begin
                state_r      <= ST_CALC;
                start_calc_r <= 1'b1;
            end
        end else begin
            start_calc_r <= 1'b0;
            case (state_r)
                ST_CALC: begin
                    done_mask_r   <= merged_mask_s;
                    cycle_count_r <= count_inc_s;
                    if (all_done_s) begin
                        state_r <= ST_POP;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_POP: begin
                    cycle_count_r <= count_inc_s;
                    if (populate_done) begin
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_POP;
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

`ifdef SIEVE_CTRL_TIMEOUT_EN
    logic timed_out_r;

    // Sticky watchdog flag, cleared only by reset or the next accepted run.
    always_ff @(posedge clk) begin
        if (reset) begin
            timed_out_r <= 1'b0;
        end else if (abort_s) begin
            timed_out_r <= timed_out_r;
        end else if (watchdog_s) begin
            timed_out_r <= 1'b1;
        end else if (accept_s) begin
            timed_out_r <= 1'b0;
        end else begin
            timed_out_r <= timed_out_r;
        end
    end

    assign timed_out = timed_out_r;
`else
    assign timed_out = 1'b0;
`endif

    assign start_calc  = start_calc_r;
    assign max_prime   = max_prime_r;
    assign cycle_count = cycle_count_r;
    assign calculating = (state_r == ST_CALC);
    assign populating  = (state_r == ST_POP);
    assign finished    = (state_r == ST_FIN);

endmodule

// File: tb/tb_sieve_controller_mb.sv
// Bench for sieve_controller_mb: directed scenarios plus randomized traffic against a cycle model.
// A second instance with CNT_W=3 shares the stimulus to observe count saturation.
module tb_sieve_controller_mb;

    localparam int TO = 16;
`ifdef SIEVE_CTRL_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif
    localparam int S_IDLE = 0;
    localparam int S_CALC = 1;
    localparam int S_POP  = 2;
    localparam int S_FIN  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        calculate = 1'b0;
    logic [15:0] max_prime_in = 16'd0;
    logic        new_max_prime = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  bank_done = 4'd0;
    logic        populate_done = 1'b0;

    logic        start_calc, calculating, populating, finished, timed_out;
    logic [15:0] max_prime;
    logic [23:0] cycle_count;
    logic        start_calc_sat, calculating_sat, populating_sat, finished_sat, timed_out_sat;
    logic [15:0] max_prime_sat;
    logic [2:0]  cycle_count_sat;

    sieve_controller_mb #(.NUM_BANKS(4), .MAX_W(16), .CNT_W(24), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .calculate(calculate), .max_prime_in(max_prime_in),
        .new_max_prime(new_max_prime), .abort(abort), .bank_done(bank_done),
        .populate_done(populate_done), .start_calc(start_calc), .max_prime(max_prime),
        .calculating(calculating), .populating(populating), .finished(finished),
        .cycle_count(cycle_count), .timed_out(timed_out)
    );

    sieve_controller_mb #(.NUM_BANKS(4), .MAX_W(16), .CNT_W(3), .TIMEOUT_CYCLES(TO)) dut_sat (
        .clk(clk), .reset(reset), .calculate(calculate), .max_prime_in(max_prime_in),
        .new_max_prime(new_max_prime), .abort(abort), .bank_done(bank_done),
        .populate_done(populate_done), .start_calc(start_calc_sat), .max_prime(max_prime_sat),
        .calculating(calculating_sat), .populating(populating_sat), .finished(finished_sat),
        .cycle_count(cycle_count_sat), .timed_out(timed_out_sat)
    );

    always #5 clk = ~clk;

    int start_seen = 0;
    always @(negedge clk) if (start_calc === 1'b1) start_seen++;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run phase, bank set, unsaturated run length.
    int       m_state = S_IDLE;
    bit [3:0] m_mask  = 4'd0;
    int       m_cnt   = 0;
    bit       m_start = 1'b0;
    bit [15:0] m_max  = 16'd0;
    bit       m_to    = 1'b0;

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic model_edge();
        bit acc;
        if (reset) begin
            m_state = S_IDLE; m_mask = 4'd0; m_cnt = 0; m_start = 1'b0; m_max = 16'd0; m_to = 1'b0;
        end else begin
            acc = (m_state == S_IDLE) ? calculate : (new_max_prime && !abort);
            m_start = 1'b0;
            if (m_state != S_IDLE && abort) begin
                m_state = S_IDLE;
            end else if (WD_ON && (m_state == S_CALC || m_state == S_POP) && m_cnt == TO - 1) begin
                m_state = S_IDLE; m_to = 1'b1; m_cnt++;
            end else if (acc) begin
                m_max = max_prime_in; m_cnt = 0; m_mask = 4'd0; m_to = 1'b0;
                if (max_prime_in >= 2) begin
                    m_state = S_CALC; m_start = 1'b1;
                end else begin
                    m_state = S_FIN;
                end
            end else if (m_state == S_CALC) begin
                m_cnt++;
                m_mask = m_mask | bank_done;
                if (m_mask == 4'hF) m_state = S_POP;
            end else if (m_state == S_POP) begin
                m_cnt++;
                if (populate_done) m_state = S_FIN;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0; calculate = 1'b0; new_max_prime = 1'b0; abort = 1'b0;
        bank_done = 4'd0; populate_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        quiet();
        n_checks++;
        if ({start_calc, calculating, populating, finished, timed_out} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                               {start_calc, calculating, populating, finished, timed_out});
        end
        n_checks++;
        if (max_prime !== 16'd0 || cycle_count !== 24'd0) begin
            n_fail++; $display("FAIL reset_values: max_prime %0d cycle_count %0d expected 0 0", max_prime, cycle_count);
        end
    endtask

    task automatic test_basic_run();
        int s0;
        s0 = start_seen;
        calculate = 1'b1; max_prime_in = 16'd100;
        tick();
        calculate = 1'b0;
        n_checks++;
        if (start_calc !== 1'b1 || calculating !== 1'b1 || max_prime !== 16'd100) begin
            n_fail++; $display("FAIL basic_start: start %b calc %b max %0d expected 1 1 100", start_calc, calculating, max_prime);
        end
        repeat (4) tick();
        bank_done = 4'hF;
        tick();
        bank_done = 4'h0;
        repeat (2) tick();
        populate_done = 1'b1;
        tick();
        populate_done = 1'b0;
        tick();
        n_checks++;
        if (finished !== 1'b1 || cycle_count !== 24'd8 || max_prime !== 16'd100) begin
            n_fail++; $display("FAIL basic_done: fin %b count %0d max %0d expected 1 8 100", finished, cycle_count, max_prime);
        end
        n_checks++;
        if (start_seen - s0 !== 1) begin
            n_fail++; $display("FAIL basic_pulses: got %0d start pulses expected 1", start_seen - s0);
        end
    endtask

    task automatic test_staggered_banks();
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        new_max_prime = 1'b1; max_prime_in = 16'd200;
        tick();
        new_max_prime = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bank_done = seq[i];
            tick();
            n_checks++;
            if (populating !== (i == 3) || calculating !== (i != 3)) begin
                n_fail++; $display("FAIL stagger_%0d: pop %b calc %b expected %b %b",
                                   i, populating, calculating, i == 3, i != 3);
            end
        end
        bank_done = 4'd0;
        populate_done = 1'b1;
        tick();
        populate_done = 1'b0;
        n_checks++;
        if (finished !== 1'b1 || cycle_count !== 24'd5) begin
            n_fail++; $display("FAIL stagger_finish: fin %b count %0d expected 1 5", finished, cycle_count);
        end
    endtask

    task automatic test_restart();
        new_max_prime = 1'b1; max_prime_in = 16'd300;
        tick();
        new_max_prime = 1'b0; bank_done = 4'hF;
        tick();
        bank_done = 4'h0;
        tick();
        new_max_prime = 1'b1; max_prime_in = 16'd50; populate_done = 1'b1;
        tick();
        new_max_prime = 1'b0; populate_done = 1'b0;
        n_checks++;
        if (calculating !== 1'b1 || finished !== 1'b0 || start_calc !== 1'b1) begin
            n_fail++; $display("FAIL restart_state: calc %b fin %b start %b expected 1 0 1", calculating, finished, start_calc);
        end
        n_checks++;
        if (max_prime !== 16'd50 || cycle_count !== 24'd0) begin
            n_fail++; $display("FAIL restart_values: max %0d count %0d expected 50 0", max_prime, cycle_count);
        end
        bank_done = 4'b0101;
        tick();
        new_max_prime = 1'b1; max_prime_in = 16'd60; bank_done = 4'b1010;
        tick();
        new_max_prime = 1'b0; bank_done = 4'd0;
        tick();
        n_checks++;
        if (calculating !== 1'b1 || populating !== 1'b0) begin
            n_fail++; $display("FAIL restart_stale_mask: calc %b pop %b expected 1 0", calculating, populating);
        end
    endtask

    task automatic test_abort_bypass();
        int s0;
        int held;
        tick();
        held = m_cnt;
        s0 = start_seen;
        abort = 1'b1; new_max_prime = 1'b1; max_prime_in = 16'd77;
        tick();
        abort = 1'b0; new_max_prime = 1'b0;
        n_checks++;
        if ({calculating, populating, finished, start_calc} !== 4'b0 || max_prime !== 16'd60) begin
            n_fail++; $display("FAIL abort_idle: flags %b max %0d expected 0000 60",
                               {calculating, populating, finished, start_calc}, max_prime);
        end
        n_checks++;
        if (cycle_count !== 24'(held)) begin
            n_fail++; $display("FAIL abort_count_hold: got %0d expected %0d", cycle_count, held);
        end
        calculate = 1'b1; max_prime_in = 16'd1;
        tick();
        calculate = 1'b0;
        tick();
        n_checks++;
        if (finished !== 1'b1 || cycle_count !== 24'd0 || max_prime !== 16'd1 || start_seen - s0 !== 0) begin
            n_fail++; $display("FAIL bypass: fin %b count %0d max %0d pulses %0d expected 1 0 1 0",
                               finished, cycle_count, max_prime, start_seen - s0);
        end
        calculate = 1'b1; max_prime_in = 16'd9;
        tick();
        calculate = 1'b0;
        n_checks++;
        if (finished !== 1'b1 || max_prime !== 16'd1) begin
            n_fail++; $display("FAIL calc_ignored_in_finished: fin %b max %0d expected 1 1", finished, max_prime);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_watchdog();
        calculate = 1'b1; max_prime_in = 16'd10;
        tick();
        calculate = 1'b0;
        repeat (TO - 1) tick();
        n_checks++;
        if (calculating !== 1'b1 || timed_out !== 1'b0) begin
            n_fail++; $display("FAIL wdog_before: calc %b to %b expected 1 0", calculating, timed_out);
        end
        tick();
        n_checks++;
        if (calculating !== WD_ON ? 1'b0 : 1'b1) begin
        end
        if (calculating !== !WD_ON || timed_out !== WD_ON) begin
            n_fail++; $display("FAIL wdog_fire: calc %b to %b expected %b %b", calculating, timed_out, !WD_ON, WD_ON);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        calculate = 1'b1; max_prime_in = 16'd11;
        tick();
        calculate = 1'b0;
        n_checks++;
        if (timed_out !== 1'b0 || calculating !== 1'b1) begin
            n_fail++; $display("FAIL wdog_clear: to %b calc %b expected 0 1", timed_out, calculating);
        end
        repeat (TO - 1) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (timed_out !== 1'b0 || calculating !== 1'b0) begin
            n_fail++; $display("FAIL wdog_abort_wins: to %b calc %b expected 0 0", timed_out, calculating);
        end
    endtask

    task automatic test_saturation();
        calculate = 1'b1; max_prime_in = 16'd9;
        tick();
        calculate = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (!WD_ON && (cycle_count_sat !== 3'd7 || cycle_count !== 24'd12)) begin
            n_fail++; $display("FAIL saturation: narrow %0d wide %0d expected 7 12", cycle_count_sat, cycle_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_mid_reset();
        calculate = 1'b1; max_prime_in = 16'd100;
        tick();
        calculate = 1'b0; bank_done = 4'b0011;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; bank_done = 4'd0;
        n_checks++;
        if ({start_calc, calculating, populating, finished, timed_out} !== 5'b0 ||
            max_prime !== 16'd0 || cycle_count !== 24'd0 || cycle_count_sat !== 3'd0) begin
            n_fail++; $display("FAIL mid_reset: flags %b max %0d count %0d narrow %0d expected 0",
                               {start_calc, calculating, populating, finished, timed_out},
                               max_prime, cycle_count, cycle_count_sat);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            calculate     = ($urandom_range(0, 9) < 3);
            new_max_prime = ($urandom_range(0, 39) < 2);
            abort         = ($urandom_range(0, 39) == 0);
            bank_done     = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            populate_done = ($urandom_range(0, 4) == 0);
            max_prime_in  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            tick();
            n_checks++;
            if (calculating !== (m_state == S_CALC) || populating !== (m_state == S_POP) ||
                finished !== (m_state == S_FIN) || start_calc !== m_start) begin
                n_fail++; $display("FAIL rand_state cyc %0d: c/p/f/s %b%b%b%b expected state %0d start %b",
                                   i, calculating, populating, finished, start_calc, m_state, m_start);
            end
            n_checks++;
            if (max_prime !== m_max || cycle_count !== 24'(m_cnt) || timed_out !== m_to) begin
                n_fail++; $display("FAIL rand_values cyc %0d: max %0d count %0d to %b expected %0d %0d %b",
                                   i, max_prime, cycle_count, timed_out, m_max, m_cnt, m_to);
            end
            if (!WD_ON) begin
                n_checks++;
                if (cycle_count_sat !== 3'(sat7(m_cnt))) begin
                    n_fail++; $display("FAIL rand_sat cyc %0d: got %0d expected %0d", i, cycle_count_sat, sat7(m_cnt));
                end
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_staggered_banks();
        test_restart();
        test_abort_bypass();
        test_watchdog();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
